// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file with per-register pending bits and post-reset clear sweep
// Ports: clk, reset (async, active-high), clr_req (re-clear request while ready), ready (sweep done),
//   rs1_addr/rs1_data/rs1_busy and rs2_addr/rs2_data/rs2_busy (combinational reads),
//   alloc_en/alloc_addr (mark destination pending), wr_en/wr_addr/wr_data (writeback).
// Define RF_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_scoreboard #(
    parameter int XLEN = 32,
    parameter int AW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr_req,
    output logic            ready,
    input  logic [AW-1:0]   rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic            rs1_busy,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs2_busy,
    input  logic            alloc_en,
    input  logic [AW-1:0]   alloc_addr,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data
);
    localparam int NREG = 2 ** AW;
    typedef enum logic {CLEAR, READY} state_t;
    state_t          state, state_nxt;
    logic [AW-1:0]   clr_ptr, clr_ptr_nxt;
    logic [NREG-1:0] pending;
    logic [XLEN-1:0] regs [NREG];
    logic            do_wr, do_alloc, byp1, byp2;
    always_comb begin
        state_nxt = state;
        clr_ptr_nxt = clr_ptr;
        if (state == CLEAR) begin
            clr_ptr_nxt = clr_ptr + 1'b1;
            state_nxt = (clr_ptr == {AW{1'b1}}) ? READY : CLEAR;
        end else if (clr_req) begin
            state_nxt = CLEAR;
            clr_ptr_nxt = AW'(1);
        end
    end
    assign ready = state == READY;
    // the edge that starts a re-clear drops any write/alloc presented with it
    assign do_wr = ready && !clr_req && wr_en && wr_addr != '0;
    assign do_alloc = ready && !clr_req && alloc_en && alloc_addr != '0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            clr_ptr <= AW'(1);
            pending <= '0;
        end else begin
            state <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
            if (ready && clr_req) pending <= '0;
            else begin
                if (do_wr) pending[wr_addr] <= 1'b0;
                // alloc after writeback so a new producer on the same edge keeps the bit set
                if (do_alloc) pending[alloc_addr] <= 1'b1;
            end
        end
    end
    // storage has no reset; x0 is never written and is masked on read
    always_ff @(posedge clk) begin
        if (state == CLEAR) regs[clr_ptr] <= '0;
        else if (do_wr) regs[wr_addr] <= wr_data;
    end
`ifdef RF_BYPASS_EN
    assign byp1 = ready && wr_en && wr_addr != '0 && rs1_addr == wr_addr;
    assign byp2 = ready && wr_en && wr_addr != '0 && rs2_addr == wr_addr;
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif
    assign rs1_data = (!ready || rs1_addr == '0) ? '0 : byp1 ? wr_data : regs[rs1_addr];
    assign rs2_data = (!ready || rs2_addr == '0) ? '0 : byp2 ? wr_data : regs[rs2_addr];
    assign rs1_busy = ready && rs1_addr != '0 && !byp1 && pending[rs1_addr];
    assign rs2_busy = ready && rs2_addr != '0 && !byp2 && pending[rs2_addr];
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed self-checking bench for regfile_scoreboard (XLEN=32, AW=5)
module tb_regfile_scoreboard;
    logic        clk, reset, clr_req, ready;
    logic [4:0]  rs1_addr, rs2_addr, alloc_addr, wr_addr;
    logic [31:0] rs1_data, rs2_data, wr_data;
    logic        rs1_busy, rs2_busy, alloc_en, wr_en;
    int          n_chk = 0, n_fail = 0, n;

    regfile_scoreboard #(.XLEN(32), .AW(5)) dut (
        .clk(clk), .reset(reset), .clr_req(clr_req), .ready(ready),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs1_busy(rs1_busy),
        .rs2_addr(rs2_addr), .rs2_data(rs2_data), .rs2_busy(rs2_busy),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!ready && cnt < 200) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        reset = 1; clr_req = 0; alloc_en = 0; wr_en = 0;
        rs1_addr = 0; rs2_addr = 0; alloc_addr = 0; wr_addr = 0; wr_data = 0;
        step(); step();
        rs1_addr = 5;
        #1;
        check("reset_ready", {31'b0, ready}, 0);
        check("reset_rs1", rs1_data, 0);
        reset = 0;
        wait_ready(n);
        check("sweep_edges", n, 31);
        for (int i = 1; i < 32; i++) begin
            rs1_addr = 5'(i);
            #1;
            check($sformatf("clear_x%0d", i), rs1_data, 0);
        end

        wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        step();
        wr_en = 0; rs1_addr = 5; rs2_addr = 5;
        #1;
        check("wr5_rs1", rs1_data, 32'hDEADBEEF);
        check("wr5_rs2", rs2_data, 32'hDEADBEEF);
        wr_en = 1; wr_addr = 0; wr_data = 32'h1234;
        step();
        wr_en = 0; rs1_addr = 0;
        #1;
        check("x0_data", rs1_data, 0);
        check("x0_busy", {31'b0, rs1_busy}, 0);

        alloc_en = 1; alloc_addr = 7;
        step();
        alloc_en = 0; rs1_addr = 7;
        #1;
        check("alloc7_busy", {31'b0, rs1_busy}, 1);
        wr_en = 1; wr_addr = 7; wr_data = 32'h55;
        step();
        wr_en = 0;
        #1;
        check("wr7_busy", {31'b0, rs1_busy}, 0);
        check("wr7_data", rs1_data, 32'h55);
        alloc_en = 1; alloc_addr = 7; wr_en = 1; wr_addr = 7; wr_data = 32'h66;
        step();
        wr_en = 0;
        #1;
        check("both7_busy", {31'b0, rs1_busy}, 1);
        check("both7_data", rs1_data, 32'h66);
        alloc_addr = 0;
        step();
        alloc_en = 0; rs2_addr = 0;
        #1;
        check("realloc7_busy", {31'b0, rs1_busy}, 1);
        check("alloc0_busy", {31'b0, rs2_busy}, 0);

        alloc_en = 1; alloc_addr = 9;
        step();
        alloc_en = 0; wr_en = 1; wr_addr = 9; wr_data = 32'hA5A5A5A5; rs2_addr = 9;
        #1;
`ifdef RF_BYPASS_EN
        check("byp9_data", rs2_data, 32'hA5A5A5A5);
        check("byp9_busy", {31'b0, rs2_busy}, 0);
`else
        check("nobyp9_data", rs2_data, 0);
        check("nobyp9_busy", {31'b0, rs2_busy}, 1);
`endif
        step();
        wr_en = 0;
        #1;
        check("wr9_data", rs2_data, 32'hA5A5A5A5);
        check("wr9_busy", {31'b0, rs2_busy}, 0);

        wr_en = 1; wr_addr = 3; wr_data = 32'h77; alloc_en = 1; alloc_addr = 4;
        step();
        wr_en = 0; alloc_en = 0; rs1_addr = 3; rs2_addr = 4;
        #1;
        check("pre_clr_x3", rs1_data, 32'h77);
        check("pre_clr_x4busy", {31'b0, rs2_busy}, 1);
        clr_req = 1; wr_en = 1; wr_addr = 5; wr_data = 32'h99; alloc_en = 1; alloc_addr = 5;
        step();
        clr_req = 0; wr_addr = 2; wr_data = 32'hBB; alloc_addr = 6;
        #1;
        check("clr_ready", {31'b0, ready}, 0);
        wait_ready(n);
        wr_en = 0; alloc_en = 0;
        check("clr_edges", n, 31);
        #1;
        check("post_clr_x3", rs1_data, 0);
        check("post_clr_x4busy", {31'b0, rs2_busy}, 0);
        rs1_addr = 2; rs2_addr = 6;
        #1;
        check("sweep_wr_dropped", rs1_data, 0);
        check("sweep_alloc_dropped", {31'b0, rs2_busy}, 0);
        rs1_addr = 5;
        #1;
        check("clr_edge_wr_dropped", rs1_data, 0);
        check("clr_edge_alloc_dropped", {31'b0, rs1_busy}, 0);

        wr_en = 1; wr_addr = 10; wr_data = 32'h1010; alloc_en = 1; alloc_addr = 8;
        step();
        wr_en = 0; alloc_en = 0; rs1_addr = 10; rs2_addr = 8;
        #1;
        check("pre_rst_x10", rs1_data, 32'h1010);
        check("pre_rst_x8busy", {31'b0, rs2_busy}, 1);
        clr_req = 1;
        step();
        clr_req = 0;
        repeat (9) step();
        #2;
        reset = 1;
        #1;
        check("midsweep_rst_ready", {31'b0, ready}, 0);
        check("midsweep_rst_busy", {31'b0, rs2_busy}, 0);
        step();
        reset = 0;
        wait_ready(n);
        check("rst_sweep_edges", n, 31);
        #1;
        check("post_rst_x10", rs1_data, 0);
        check("post_rst_x8busy", {31'b0, rs2_busy}, 0);

        alloc_en = 1; alloc_addr = 8;
        step();
        alloc_en = 0;
        #2;
        reset = 1;
        #1;
        check("async_rst_ready", {31'b0, ready}, 0);
        check("async_rst_busy", {31'b0, rs2_busy}, 0);
        reset = 0;
        wait_ready(n);
        #1;
        check("async_rst_pending_cleared", {31'b0, rs2_busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
